// File: rtl/pipe_skid_chain_pkg.sv
// Shared constants and types for the elastic pipeline-register chain.
package pipe_skid_chain_pkg;

  localparam int CNT_W = 2;

  // Per-stage live-entry count: 0, 1 or 2 (main + skid).
  typedef logic [CNT_W-1:0] stage_cnt_t;

  // Width needed to count 0..2*stages live beats.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_chain_stage.sv
// One elastic stage: a main entry plus a skid entry, so the upstream ready
// comes straight from a flop. A flush empties both entries at the edge.
module pipe_skid_chain_stage
  import pipe_skid_chain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             down_valid_o,
  input  logic             down_ready_i,
  output logic [WIDTH-1:0] down_data_o,
  input  logic             flush_i,
  output stage_cnt_t       count_o
);

  logic             m_v_q, m_v_d;
  logic             s_v_q, s_v_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             in_xfer;
  logic             out_xfer;

  assign up_ready_o   = ~s_v_q;
  assign down_valid_o = m_v_q & ~flush_i;
  assign down_data_o  = m_data_q;
  assign in_xfer      = up_valid_i & up_ready_o;
  assign out_xfer     = down_valid_o & down_ready_i;
  assign count_o      = {1'b0, m_v_q} + {1'b0, s_v_q};

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    m_v_d    = m_v_q;
    s_v_d    = s_v_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush_i) begin
      // A beat accepted upstream this edge is swallowed along with the stage.
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (out_xfer) begin
      if (s_v_q) begin
        m_v_d    = 1'b1;
        m_data_d = s_data_q;
        s_v_d    = in_xfer;
        if (in_xfer) s_data_d = up_data_i;
      end else begin
        m_v_d = in_xfer;
        if (in_xfer) m_data_d = up_data_i;
      end
    end else if (in_xfer) begin
      if (!m_v_q) begin
        m_v_d    = 1'b1;
        m_data_d = up_data_i;
      end else begin
        s_v_d    = 1'b1;
        s_data_d = up_data_i;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every stage samples
  // its neighbours' pre-edge values, whatever order the blocks evaluate in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      // NOTE: payload flops are reset too, so OUT_DATA reads 0 out of reset
      // rather than whatever the silicon powered up with.
      m_data_q <= '0;
      s_data_q <= '0;
    end else begin
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: rtl/pipe_skid_chain.sv
// Valid/ready chain of STAGES skid stages between a producer and consumer;
// each stage can be squashed by its own flush bit.
module pipe_skid_chain
  import pipe_skid_chain_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 4,
  localparam int OCC_W  = occ_width(STAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WIDTH-1:0]  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WIDTH-1:0]  out_data_o,
  input  logic [STAGES-1:0] flush_i,
  output logic [OCC_W-1:0]  occupancy_o
);

  // Link i sits in front of stage i; link STAGES is the chain output.
  logic [STAGES:0]            valid_w;
  logic [STAGES:0]            ready_w;
  logic [STAGES:0][WIDTH-1:0] data_w;
  stage_cnt_t                 cnt_w [STAGES];

  assign valid_w[0]      = in_valid_i;
  assign data_w[0]       = in_data_i;
  assign in_ready_o      = ready_w[0];
  assign ready_w[STAGES] = out_ready_i;
  assign out_valid_o     = valid_w[STAGES];
  assign out_data_o      = data_w[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_skid_chain_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .up_valid_i  (valid_w[i]),
      .up_ready_o  (ready_w[i]),
      .up_data_i   (data_w[i]),
      .down_valid_o(valid_w[i+1]),
      .down_ready_i(ready_w[i+1]),
      .down_data_o (data_w[i+1]),
      .flush_i     (flush_i[i]),
      .count_o     (cnt_w[i])
    );
  end

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy_o = occupancy_o + OCC_W'(cnt_w[i]);
    end
  end

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Scoreboard bench for pipe_skid_chain: three chains (4, 3 and 1 stages)
// under random traffic, plus directed latency/backpressure/flush/reset cases.
module tb_pipe_skid_chain;
  import pipe_skid_chain_pkg::*;

  localparam int W  = 32;
  localparam int NL = 3;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int S  = (g == 0) ? 4 : (g == 1) ? 3 : 1;
    localparam int OW = occ_width(S);

    logic          in_valid_l, in_ready_l, out_valid_l, out_ready_l;
    logic [W-1:0]  in_data_l, out_data_l;
    logic [S-1:0]  flush_l;
    logic [OW-1:0] occ_l;
    logic [W-1:0]  sb [$];
    bit            done;

    pipe_skid_chain #(
      .WIDTH (W),
      .STAGES(S)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid_l),
      .in_ready_o (in_ready_l),
      .in_data_i  (in_data_l),
      .out_valid_o(out_valid_l),
      .out_ready_i(out_ready_l),
      .out_data_o (out_data_l),
      .flush_i    (flush_l),
      .occupancy_o(occ_l)
    );

    // Monitor: the queue holds the live beats oldest-first; inputs are stable
    // around each negedge, so handshakes seen here are the next edge's.
    initial begin : monitor
      logic [W-1:0] exp_d;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          sb.delete();
        end else begin
          check($sformatf("occupancy[S=%0d]", S), 64'(occ_l), 64'(sb.size()));
          if (out_valid_l && out_ready_l) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL out_unexpected[S=%0d]: got 0x%0h, expected no beat", S, out_data_l);
            end else begin
              exp_d = sb.pop_front();
              check($sformatf("out_data[S=%0d]", S), 64'(out_data_l), 64'(exp_d));
            end
          end
          if (flush_l != '0) begin
            if (&flush_l) begin
              sb.delete();
            end else begin
              // Partial flushes are only issued on a full, stalled chain, where
              // stage k holds queue positions 2*(S-1-k) and 2*(S-1-k)+1.
              for (int k = 0; k < S; k++) begin
                if (flush_l[k]) begin
                  sb.delete(2 * (S - 1 - k) + 1);
                  sb.delete(2 * (S - 1 - k));
                end
              end
            end
            if (in_valid_l && in_ready_l && !flush_l[0]) sb.push_back(in_data_l);
          end else if (in_valid_l && in_ready_l) begin
            sb.push_back(in_data_l);
          end
        end
      end
    end

    if (g == 0) begin : directed
      task automatic fill(input logic [W-1:0] base, input int offers, output int acc);
        acc         = 0;
        out_ready_l = 1'b0;
        for (int k = 0; k < offers; k++) begin
          in_valid_l = 1'b1;
          in_data_l  = base + W'(acc);
          @(negedge clk);
          if (in_ready_l) acc++;
          step();
        end
        in_valid_l = 1'b0;
      endtask

      task automatic drain(input int cycles, output int n_out);
        n_out       = 0;
        out_ready_l = 1'b1;
        for (int k = 0; k < cycles; k++) begin
          @(negedge clk);
          if (out_valid_l) n_out++;
          step();
        end
      endtask

      initial begin : driver
        int acc;
        int n_out;
        int first_k;
        done        = 1'b0;
        rst_n       = 1'b0;
        in_valid_l  = 1'b0;
        in_data_l   = '0;
        out_ready_l = 1'b0;
        flush_l     = '0;
        #2;
        check("reset_out_valid", 64'(out_valid_l), 64'd0);
        check("reset_out_data", 64'(out_data_l), 64'd0);
        check("reset_occupancy", 64'(occ_l), 64'd0);
        check("reset_in_ready", 64'(in_ready_l), 64'd1);
        repeat (2) step();
        rst_n = 1'b1;

        // Streaming: 1..8 offered back to back, first out in cycle S.
        out_ready_l = 1'b1;
        for (int k = 0; k < 13; k++) begin
          in_valid_l = (k < 8);
          in_data_l  = W'(k + 1);
          @(negedge clk);
          check($sformatf("stream_out_valid_c%0d", k), 64'(out_valid_l), 64'((k >= S) && (k < S + 8)));
          if (k < 8) check($sformatf("stream_in_ready_c%0d", k), 64'(in_ready_l), 64'd1);
          step();
        end
        in_valid_l = 1'b0;

        // Backpressure: 16 offers, only 2*S fit.
        fill(32'hA0, 16, acc);
        check("bp_accepted", 64'(acc), 64'(2 * S));
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready_l), 64'd0);
        check("bp_occupancy", 64'(occ_l), 64'(2 * S));
        step();
        out_ready_l = 1'b1;
        first_k     = -1;
        for (int k = 0; k < 2 * S + 2; k++) begin
          @(negedge clk);
          check($sformatf("bp_drain_valid_c%0d", k), 64'(out_valid_l), 64'(k < 2 * S));
          if (in_ready_l && first_k < 0) first_k = k;
          step();
        end
        check("bp_ready_return", 64'((first_k >= 0) && (first_k <= S)), 64'd1);

        // Middle-stage flush on a full chain.
        fill(32'hB0, 2 * S + 4, acc);
        check("flush_mid_filled", 64'(acc), 64'(2 * S));
        flush_l = 4'b0110;
        @(negedge clk);
        step();
        flush_l = '0;
        @(negedge clk);
        check("flush_mid_occupancy", 64'(occ_l), 64'(2 * S - 4));
        step();
        drain(2 * S + 2, n_out);
        check("flush_mid_survivors", 64'(n_out), 64'(2 * S - 4));

        // Flush everything while a 0x55 beat is offered.
        fill(32'hC0, 3, acc);
        check("flush_all_prefill", 64'(acc), 64'd3);
        flush_l    = '1;
        in_valid_l = 1'b1;
        in_data_l  = W'(32'h55);
        @(negedge clk);
        check("flush_all_handshake", 64'(in_ready_l), 64'd1);
        step();
        flush_l    = '0;
        in_valid_l = 1'b0;
        @(negedge clk);
        check("flush_all_occupancy", 64'(occ_l), 64'd0);
        step();
        drain(2 * S + 2, n_out);
        check("flush_all_no_output", 64'(n_out), 64'd0);

        // Asynchronous reset mid-stream on a full chain.
        fill(32'hD0, 2 * S + 2, acc);
        check("reset_mid_filled", 64'(occ_l), 64'(2 * S));
        rst_n = 1'b0;
        #1;
        check("reset_mid_out_valid", 64'(out_valid_l), 64'd0);
        check("reset_mid_out_data", 64'(out_data_l), 64'd0);
        check("reset_mid_occupancy", 64'(occ_l), 64'd0);
        check("reset_mid_in_ready", 64'(in_ready_l), 64'd1);
        step();
        rst_n       = 1'b1;
        out_ready_l = 1'b1;
        in_valid_l  = 1'b1;
        in_data_l   = W'(32'hE1);
        for (int k = 0; k < S + 3; k++) begin
          @(negedge clk);
          check($sformatf("post_reset_valid_c%0d", k), 64'(out_valid_l), 64'(k == S));
          step();
          in_valid_l = 1'b0;
        end

        // Random traffic, then a full drain.
        for (int c = 0; c < 10000; c++) begin
          in_valid_l  = ($urandom_range(3) != 0);
          in_data_l   = W'($urandom);
          out_ready_l = ($urandom_range(2) != 0);
          step();
        end
        in_valid_l  = 1'b0;
        out_ready_l = 1'b1;
        repeat (2 * S + 2) step();
        @(negedge clk);
        check("random_drain_empty[S=4]", 64'(sb.size()), 64'd0);
        done = 1'b1;
      end
    end else begin : random_only
      initial begin : driver
        done        = 1'b0;
        in_valid_l  = 1'b0;
        in_data_l   = '0;
        out_ready_l = 1'b0;
        flush_l     = '0;
        @(posedge rst_n);
        step();
        for (int c = 0; c < 10000; c++) begin
          in_valid_l  = ($urandom_range(3) != 0);
          in_data_l   = W'($urandom);
          out_ready_l = ($urandom_range(2) != 0);
          step();
        end
        in_valid_l  = 1'b0;
        out_ready_l = 1'b1;
        repeat (2 * S + 2) step();
        @(negedge clk);
        check($sformatf("random_drain_empty[S=%0d]", S), 64'(sb.size()), 64'd0);
        done = 1'b1;
      end
    end
  end

  initial begin : finisher
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      if (lane[0].done && lane[1].done && lane[2].done) break;
    end
    #3;
    check("all_lanes_done", 64'({lane[0].done, lane[1].done, lane[2].done}), 64'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
